sd_dram_writer: RTL and testbench

- Sits directly downstream of the SD-card boot loader.
- Consumes the loader's 32-bit word stream (data, write strobe, done) and buffers it in a small FIFO.
- Writes each word sequentially into DRAM through a request/busy handshake, absorbing DRAM stalls (including refresh periods).
- Reports running word count, additive checksum, overflow and a final "image in DRAM" done flag to the boot sequencer.

---
 rtl/sd_dram_writer_if.sv | 30 +++
 rtl/sd_dram_writer.sv | 113 +++++++++++
 tb/tb_sd_dram_writer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dram_writer_if.sv
// Loader-stream, DRAM-handshake and status signals of the SD-to-DRAM writer.
// The slave modport is the writer's view; master is the surrounding system's view.
interface sd_dram_writer_if #(
  parameter int unsigned ADDR_W = 27
) ();
  logic [31:0]       i_data;
  logic              i_we;
  logic              i_done;
  logic              w_dram_busy;
  logic              o_dram_we;
  logic [ADDR_W-1:0] o_dram_addr;
  logic [31:0]       o_dram_wdata;
  logic              o_fifo_full;
  logic              o_overflow;
  logic [23:0]       o_word_count;
  logic [31:0]       o_checksum;
  logic              o_done;

  modport slave (
    input  i_data, i_we, i_done, w_dram_busy,
    output o_dram_we, o_dram_addr, o_dram_wdata, o_fifo_full,
           o_overflow, o_word_count, o_checksum, o_done
  );

  modport master (
    output i_data, i_we, i_done, w_dram_busy,
    input  o_dram_we, o_dram_addr, o_dram_wdata, o_fifo_full,
           o_overflow, o_word_count, o_checksum, o_done
  );
endinterface

// File: rtl/sd_dram_writer.sv
// Buffers the SD boot loader's word stream in a FIFO and writes it sequentially
// into DRAM over a request/busy handshake, tracking count, checksum and completion.
module sd_dram_writer #(
  parameter int unsigned        DEPTH     = 16,
  parameter int unsigned        ADDR_W    = 27,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input logic               clk27mhz,
  input logic               reset,
  sd_dram_writer_if.slave   bus
);
  localparam int unsigned     PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_nx;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count, count_nx;
  logic              full_q;
  logic              push, pop, commit, dram_we;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [23:0]       word_cnt_q;
  logic [31:0]       checksum_q;
  logic              overflow_q, done_latch, done_q;

  // Full is judged on live occupancy so a pop in the same cycle does not admit a push.
  assign push = bus.i_we && (count != FULL_CNT);

  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + 1'b1;
    else if (!push && pop) count_nx = count - 1'b1;
  end

  always_ff @(posedge clk27mhz) begin
    if (push) mem[wr_ptr] <= bus.i_data;
  end

  always_ff @(posedge clk27mhz or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nx;
      full_q <= (count_nx == FULL_CNT);
      if (bus.i_we && (count == FULL_CNT)) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk27mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if ((count != '0) && !bus.w_dram_busy) state_nx = REQ;
      REQ:     if (bus.w_dram_busy)                   state_nx = WAIT;
      WAIT:    if (!bus.w_dram_busy)                  state_nx = IDLE;
      default:                                        state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    commit  = 1'b0;
    dram_we = 1'b0;
    case (state)
      IDLE:    pop     = (count != '0) && !bus.w_dram_busy;
      REQ:     dram_we = 1'b1;
      WAIT:    commit  = !bus.w_dram_busy;
      default: ;
    endcase
  end

  always_ff @(posedge clk27mhz or posedge reset) begin
    if (reset) begin
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      word_cnt_q <= '0;
      checksum_q <= '0;
      done_latch <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (pop) wdata_q <= mem[rd_ptr];
      if (commit) begin
        addr_q     <= addr_q + ADDR_W'(4);
        word_cnt_q <= word_cnt_q + 24'd1;
        checksum_q <= checksum_q + wdata_q;
      end
      if (bus.i_done) done_latch <= 1'b1;
      if (done_latch && (count == '0) && (state == IDLE) && !bus.i_we) done_q <= 1'b1;
    end
  end

  assign bus.o_dram_we    = dram_we;
  assign bus.o_dram_addr  = addr_q;
  assign bus.o_dram_wdata = wdata_q;
  assign bus.o_fifo_full  = full_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_word_count = word_cnt_q;
  assign bus.o_checksum   = checksum_q;
  assign bus.o_done       = done_q;
endmodule

// File: tb/tb_sd_dram_writer.sv
// Directed bench for sd_dram_writer with a small DRAM responder model.
module tb_sd_dram_writer;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 27;
  localparam logic [26:0] BASE   = 27'h0001000;

  logic clk27mhz = 1'b0;
  logic reset    = 1'b1;
  logic force_busy;
  logic model_busy;

  sd_dram_writer_if #(.ADDR_W(ADDR_W)) bus ();

  sd_dram_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk27mhz (clk27mhz),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk27mhz = ~clk27mhz;

  assign bus.w_dram_busy = force_busy | model_busy;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // DRAM responder: raises busy accept_delay cycles into a request, holds it busy_len cycles.
  int          accept_delay = 1;
  int          busy_len     = 3;
  int          m_state      = 0;
  int          m_cnt        = 0;
  int          we_pulses    = 0;
  int          we_cycles    = 0;
  bit          stable       = 1'b1;
  logic [26:0] cap_addr;
  logic [31:0] cap_data;
  logic [26:0] exp_addr;
  logic [31:0] exp_q [$];

  initial begin
    model_busy = 1'b0;
    exp_addr   = BASE;
    forever begin
      @(negedge clk27mhz);
      if (reset) begin
        m_state    = 0;
        model_busy = 1'b0;
        exp_q.delete();
        exp_addr   = BASE;
        we_pulses  = 0;
      end else begin
        case (m_state)
          0: if (bus.o_dram_we) begin
            we_pulses++;
            we_cycles = 1;
            stable    = 1'b1;
            cap_addr  = bus.o_dram_addr;
            cap_data  = bus.o_dram_wdata;
            if (exp_q.size() == 0) begin
              check("write_expected", 32'(exp_q.size()), 32'd1);
            end else begin
              check("wr_addr", 32'(bus.o_dram_addr), 32'(exp_addr));
              check("wr_data", bus.o_dram_wdata, exp_q.pop_front());
              exp_addr = exp_addr + 27'd4;
            end
            if (accept_delay <= 1) begin
              model_busy = 1'b1;
              m_cnt      = busy_len;
              m_state    = 2;
            end else begin
              m_cnt   = accept_delay - 1;
              m_state = 1;
            end
          end
          1: begin
            if (bus.o_dram_we) we_cycles++;
            if (!bus.o_dram_we || bus.o_dram_addr != cap_addr || bus.o_dram_wdata != cap_data)
              stable = 1'b0;
            m_cnt--;
            if (m_cnt == 0) begin
              model_busy = 1'b1;
              m_cnt      = busy_len;
              m_state    = 2;
            end
          end
          default: begin
            m_cnt--;
            if (m_cnt == 0) begin
              model_busy = 1'b0;
              m_state    = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk27mhz);
  endtask

  task automatic push_word(input logic [31:0] d, input bit kept);
    bus.i_data = d;
    bus.i_we   = 1'b1;
    if (kept) exp_q.push_back(d);
    @(negedge clk27mhz);
    bus.i_we = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.i_we     = 1'b0;
    bus.i_done   = 1'b0;
    force_busy   = 1'b0;
    accept_delay = 1;
    busy_len     = 3;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic wait_words(input string tag, input logic [23:0] n, input int budget);
    int k = 0;
    while (bus.o_word_count != n && k < budget) begin
      @(negedge clk27mhz);
      k++;
    end
    check(tag, 32'(bus.o_word_count), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int   k;
    logic early;
    bus.i_data = '0;
    bus.i_we   = 1'b0;
    bus.i_done = 1'b0;
    force_busy = 1'b0;
    cyc(2);

    // reset state
    check("rst_we",    32'(bus.o_dram_we), 32'd0);
    check("rst_addr",  32'(bus.o_dram_addr), 32'(BASE));
    check("rst_wdata", bus.o_dram_wdata, 32'd0);
    check("rst_full",  32'(bus.o_fifo_full), 32'd0);
    check("rst_ovf",   32'(bus.o_overflow), 32'd0);
    check("rst_count", 32'(bus.o_word_count), 32'd0);
    check("rst_cks",   bus.o_checksum, 32'd0);
    check("rst_done",  32'(bus.o_done), 32'd0);
    reset = 1'b0;
    cyc(1);

    // single word and request latency
    bus.i_data = 32'hDEADBEEF;
    bus.i_we   = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk27mhz);
    bus.i_we = 1'b0;
    check("lat_push_we", 32'(bus.o_dram_we), 32'd0);
    @(negedge clk27mhz);
    check("lat_issue_we", 32'(bus.o_dram_we), 32'd1);
    wait_words("t1_count", 24'd1, 50);
    check("t1_cks",    bus.o_checksum, 32'hDEADBEEF);
    check("t1_addr",   32'(bus.o_dram_addr), 32'(BASE) + 32'd4);
    check("t1_pulses", 32'(we_pulses), 32'd1);

    // 64-word stream then i_done
    do_reset();
    busy_len = 1;
    for (int i = 1; i <= 64; i++) begin
      push_word(32'(i), 1'b1);
      cyc(3);
    end
    bus.i_done = 1'b1;
    wait_words("t2_count", 24'd64, 600);
    cyc(2);
    check("t2_cks",    bus.o_checksum, 32'h00000820);
    check("t2_addr",   32'(bus.o_dram_addr), 32'(BASE) + 32'd256);
    check("t2_done",   32'(bus.o_done), 32'd1);
    check("t2_ovf",    32'(bus.o_overflow), 32'd0);
    check("t2_pulses", 32'(we_pulses), 32'd64);

    // backpressure: FIFO fills, 17th word dropped
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_word(32'h100 + 32'(i), 1'b1);
      if (i == 14) check("t3_full_at15", 32'(bus.o_fifo_full), 32'd0);
      if (i == 15) check("t3_full_at16", 32'(bus.o_fifo_full), 32'd1);
      cyc(3);
    end
    check("t3_ovf_before", 32'(bus.o_overflow), 32'd0);
    push_word(32'h1FF, 1'b0);
    check("t3_ovf_set", 32'(bus.o_overflow), 32'd1);
    cyc(130);
    check("t3_ovf_sticky", 32'(bus.o_overflow), 32'd1);
    check("t3_no_req",     32'(we_pulses), 32'd0);
    check("t3_count0",     32'(bus.o_word_count), 32'd0);
    force_busy = 1'b0;
    wait_words("t3_count", 24'd16, 400);
    check("t3_cks",       bus.o_checksum, 32'h00001078);
    check("t3_ovf_after", 32'(bus.o_overflow), 32'd1);
    check("t3_full_after", 32'(bus.o_fifo_full), 32'd0);
    check("t3_addr",      32'(bus.o_dram_addr), 32'(BASE) + 32'd64);
    check("t3_drained",   32'(exp_q.size()), 32'd0);

    // i_done with five words still buffered
    do_reset();
    force_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push_word(32'h11 * 32'(i), 1'b1);
      cyc(1);
    end
    bus.i_done = 1'b1;
    force_busy = 1'b0;
    k     = 0;
    early = 1'b0;
    while (bus.o_word_count != 24'd5 && k < 200) begin
      if (bus.o_done) early = 1'b1;
      @(negedge clk27mhz);
      k++;
    end
    check("t4_count",      32'(bus.o_word_count), 32'd5);
    check("t4_early_done", 32'(early), 32'd0);
    check("t4_done_last",  32'(bus.o_done), 32'd0);
    @(negedge clk27mhz);
    check("t4_done_next",  32'(bus.o_done), 32'd1);
    check("t4_cks",        bus.o_checksum, 32'h000000FF);
    push_word(32'h66, 1'b1);
    wait_words("t4_count6", 24'd6, 50);
    check("t4_done_sticky", 32'(bus.o_done), 32'd1);
    check("t4_cks6",        bus.o_checksum, 32'h00000165);

    // late acceptance
    do_reset();
    accept_delay = 10;
    push_word(32'hCAFE0001, 1'b1);
    wait_words("t5_count", 24'd1, 100);
    check("t5_we_cycles", 32'(we_cycles), 32'd10);
    check("t5_stable",    32'(stable), 32'd1);
    cyc(20);
    check("t5_count_hold", 32'(bus.o_word_count), 32'd1);
    check("t5_pulses",     32'(we_pulses), 32'd1);

    // reset while waiting on DRAM completion
    do_reset();
    busy_len = 20;
    push_word(32'h12345678, 1'b1);
    k = 0;
    while (!model_busy && k < 50) begin
      @(negedge clk27mhz);
      k++;
    end
    check("t6_busy_seen", 32'(model_busy), 32'd1);
    cyc(2);
    check("t6_in_wait", 32'(bus.o_dram_we), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_addr",  32'(bus.o_dram_addr), 32'(BASE));
    check("t6_rst_count", 32'(bus.o_word_count), 32'd0);
    check("t6_rst_cks",   bus.o_checksum, 32'd0);
    check("t6_rst_wdata", bus.o_dram_wdata, 32'd0);
    cyc(2);
    reset = 1'b0;
    busy_len = 3;
    cyc(1);
    push_word(32'hA5A5A5A5, 1'b1);
    wait_words("t6_count", 24'd1, 50);
    check("t6_cks",  bus.o_checksum, 32'hA5A5A5A5);
    check("t6_addr", 32'(bus.o_dram_addr), 32'(BASE) + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
